// File: rtl/keypad_matrix_scanner_if.sv
// Key-event handshake bundle between the keypad scanner (master) and game logic (slave).
interface keypad_matrix_scanner_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       overflow;

   modport master (output key_code, output key_valid, output key_held, output overflow,
                   input key_ready);
   modport slave  (input key_code, input key_valid, input key_held, input overflow,
                   output key_ready);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad column scanner with per-frame debounce, ghost rejection and a one-entry code register.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_matrix_scanner #(
   parameter int SCAN_DIV      = 25000,
   parameter int DEBOUNCE_CNT  = 4,
   parameter int REPEAT_FRAMES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   output logic [3:0] KEY_COL,
   input  logic [3:0] KEY_ROW,
   keypad_matrix_scanner_if.master key
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_FRAMES - 1);
`ifdef KEYPAD_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

   state_t          state;
   logic [3:0]      row_s1, row_s2;
   logic [DW-1:0]   dwell;
   logic [1:0]      col;
   logic [15:0]     snap;
   logic            frame_done;
   logic [3:0]      cand;
   logic [CW-1:0]   cnt;
   logic [RW-1:0]   rpt;

   logic            single, hit, accept;
   logic [3:0]      snap_code, acc_code;

   // Snapshot bit index is already {col,row}, so a one-hot frame decodes straight to the key code.
   always_comb begin
      snap_code = 4'd0;
      for (int i = 0; i < 16; i++)
         if (snap[i]) snap_code = 4'(i);
      single   = $onehot(snap);
      hit      = single && (snap_code == cand);
      acc_code = (state == IDLE) ? snap_code : cand;
      accept   = 1'b0;
      if (frame_done) begin
         case (state)
            IDLE:     accept = single && (DEBOUNCE_CNT == 1);
            DEBOUNCE: accept = hit && (cnt == DB_LAST);
            PRESSED:  accept = RPT_EN && hit && (rpt == RPT_LAST);
            default:  accept = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         row_s1        <= 4'hF;
         row_s2        <= 4'hF;
         dwell         <= '0;
         col           <= 2'd0;
         KEY_COL       <= 4'b1110;
         snap          <= 16'd0;
         frame_done    <= 1'b0;
         state         <= IDLE;
         cand          <= 4'd0;
         cnt           <= '0;
         rpt           <= '0;
         key.key_code  <= 4'd0;
         key.key_valid <= 1'b0;
         key.key_held  <= 1'b0;
         key.overflow  <= 1'b0;
      end else begin
         row_s1     <= KEY_ROW;
         row_s2     <= row_s1;
         frame_done <= 1'b0;

         if (dwell == DIV_LAST) begin
            dwell                   <= '0;
            snap[{col, 2'b00} +: 4] <= ~row_s2;
            col                     <= col + 2'd1;
            KEY_COL                 <= ~(4'b0001 << (col + 2'd1));
            frame_done              <= (col == 2'd3);
         end else begin
            dwell <= dwell + 1'b1;
         end

         if (frame_done) begin
            case (state)
               IDLE: if (single) begin
                  cand <= snap_code;
                  if (DEBOUNCE_CNT == 1) begin
                     state        <= PRESSED;
                     cnt          <= '0;
                     rpt          <= '0;
                     key.key_held <= 1'b1;
                  end else begin
                     state <= DEBOUNCE;
                     cnt   <= CW'(1);
                  end
               end
               DEBOUNCE: begin
                  if (hit) begin
                     if (cnt == DB_LAST) begin
                        state        <= PRESSED;
                        cnt          <= '0;
                        rpt          <= '0;
                        key.key_held <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else if (single) begin
                     cand <= snap_code;
                     cnt  <= CW'(1);
                  end else begin
                     state <= IDLE;
                     cnt   <= '0;
                  end
               end
               PRESSED: begin
                  if (hit) begin
                     cnt <= '0;
                     rpt <= (rpt == RPT_LAST) ? '0 : rpt + 1'b1;
                  end else begin
                     rpt <= '0;
                     if (cnt == DB_LAST) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        key.key_held <= 1'b0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // A fresh load takes priority over a consume landing on the same edge.
         if (accept) begin
            if (!key.key_valid || key.key_ready) begin
               key.key_code  <= acc_code;
               key.key_valid <= 1'b1;
            end else begin
               key.overflow <= 1'b1;
            end
         end else if (key.key_valid && key.key_ready) begin
            key.key_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: emulated keypad matrix, vector table plus corner sequences.
module tb_keypad_matrix_scanner;
   localparam int SD = 4;
   localparam int DC = 2;
   localparam int RF = 3;
   localparam int FR = 4 * SD;
`ifdef KEYPAD_REPEAT_EN
   localparam int EXP_REP = 3;
`else
   localparam int EXP_REP = 1;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  KEY_COL;
   logic [3:0]  KEY_ROW;
   logic [3:0]  row_l;
   logic [15:0] pressed = 16'd0;

   keypad_matrix_scanner_if kif ();

   keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_FRAMES(RF)) dut (
      .CLK(CLK), .RST(RST), .KEY_COL(KEY_COL), .KEY_ROW(KEY_ROW), .key(kif));

   always #5 CLK = ~CLK;

   // Pressed keys short their row to whichever column is currently driven low.
   always_comb begin
      row_l = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!KEY_COL[c]) row_l = row_l & ~pressed[c*4 +: 4];
   end
   assign KEY_ROW = row_l;

   int         checks = 0;
   int         errors = 0;
   int         acc    = 0;
   logic [3:0] last_code = 4'd0;

   always @(negedge CLK)
      if (!RST && kif.key_valid && kif.key_ready) begin
         acc++;
         last_code = kif.key_code;
      end

   typedef struct {
      logic [15:0] keys;
      int          frames;
      int          exp_acc;
      logic [3:0]  exp_code;
      logic        exp_held;
      logic        exp_valid;
   } vec_t;

   vec_t       vt [13];
   logic [3:0] col_exp [4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Leaves time at 1ns after the first post-reset edge, aligned to a frame start.
   task automatic do_reset(input string tag);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk({tag, " KEY_COL"}, KEY_COL, 4'b1110);
      chk({tag, " key_valid"}, kif.key_valid, 0);
      chk({tag, " key_held"}, kif.key_held, 0);
      chk({tag, " overflow"}, kif.overflow, 0);
      RST = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic run_frames(input int n, input int skip);
      repeat (FR * n - skip) @(posedge CLK);
      #1;
   endtask

   initial begin
      int skip;
      int base;

      col_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      vt[0]  = '{16'h0040, 5, 1, 4'd6, 1'b1, 1'b0};
      vt[1]  = '{16'h0000, 1, 0, 4'd0, 1'b1, 1'b0};
      vt[2]  = '{16'h0000, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[3]  = '{16'h0040, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[4]  = '{16'h0000, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[5]  = '{16'h0040, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[6]  = '{16'h0000, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[7]  = '{16'h0040, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[8]  = '{16'h0000, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[9]  = '{16'h1008, 5, 0, 4'd0, 1'b0, 1'b0};
      vt[10] = '{16'h0008, 1, 0, 4'd0, 1'b0, 1'b0};
      vt[11] = '{16'h0008, 1, 1, 4'd3, 1'b1, 1'b0};
      vt[12] = '{16'h0000, 2, 0, 4'd0, 1'b0, 1'b0};

      kif.key_ready = 1'b1;
      do_reset("reset");
      for (int k = 0; k < 4; k++) begin
         repeat (4) @(posedge CLK);
         #1;
         chk($sformatf("col step %0d", k), KEY_COL, col_exp[k]);
      end

      // Table: each record's pattern is applied for whole frames; results checked just after the final update.
      skip = 0;
      base = acc;
      pressed = vt[0].keys;
      for (int i = 0; i < 13; i++) begin
         run_frames(vt[i].frames, skip);
         if (i + 1 < 13) pressed = vt[i+1].keys;
         @(negedge CLK);
         @(negedge CLK);
         chk($sformatf("vec%0d accepts", i), acc - base, vt[i].exp_acc);
         if (vt[i].exp_acc > 0) chk($sformatf("vec%0d code", i), last_code, vt[i].exp_code);
         chk($sformatf("vec%0d held", i), kif.key_held, vt[i].exp_held);
         chk($sformatf("vec%0d valid", i), kif.key_valid, vt[i].exp_valid);
         base = acc;
         skip = 1;
      end
      repeat (FR - 1) @(posedge CLK);
      #1;

      // Backpressure: second press while the first code is still unconsumed.
      kif.key_ready = 1'b0;
      pressed = 16'h0020;
      run_frames(2, 0);
      chk("bp first valid", kif.key_valid, 1);
      chk("bp first code", kif.key_code, 5);
      chk("bp first overflow", kif.overflow, 0);
      pressed = 16'h0000;
      run_frames(2, 0);
      chk("bp released held", kif.key_held, 0);
      pressed = 16'h0200;
      run_frames(2, 0);
      chk("bp valid kept", kif.key_valid, 1);
      chk("bp code kept", kif.key_code, 5);
      chk("bp overflow", kif.overflow, 1);
      chk("bp held", kif.key_held, 1);
      kif.key_ready = 1'b1;
      @(posedge CLK);
      #1;
      kif.key_ready = 1'b0;
      chk("bp consumed", kif.key_valid, 0);
      chk("bp overflow sticky", kif.overflow, 1);

      // Reset landing mid-debounce drops the candidate and clears the sticky overflow.
      kif.key_ready = 1'b1;
      pressed = 16'h0000;
      do_reset("rst2");
      pressed = 16'h0040;
      run_frames(1, 0);
      pressed = 16'h0000;
      base = acc;
      do_reset("rst mid-debounce");
      run_frames(2, 0);
      chk("post-reset valid", kif.key_valid, 0);
      chk("post-reset held", kif.key_held, 0);
      chk("post-reset accepts", acc - base, 0);

      base = acc;
      pressed = 16'h0040;
      run_frames(10, 0);
      pressed = 16'h0000;
      @(negedge CLK);
      @(negedge CLK);
      chk("hold accepts", acc - base, EXP_REP);
      chk("hold code", last_code, 6);
      chk("hold held", kif.key_held, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Reads a 4x4 membrane keypad: it drives one column low at a time, samples the active-low row lines, debounces, and delivers one key code per press. It is the input-side counterpart of the game's LED-matrix row-scan driver and replaces raw push-button inputs (player1, restart, mode) with coded key events. Codes are delivered to game logic through a one-entry valid/ready holding register.

Parameters:
SCAN_DIV, 25000, CLK cycles each column stays driven (dwell); must be >= 2
DEBOUNCE_CNT, 4, consecutive identical frames required to accept a press or a release; must be >= 1
REPEAT_FRAMES, 64, auto-repeat interval in frames; used only with KEYPAD_REPEAT_EN

Ports:
CLK  input  1  system clock, single clock domain
RST  input  1  synchronous, active-high reset
KEY_COL  output  4  column drive, active-low, exactly one bit low
KEY_ROW  input  4  row sense, active-low, externally pulled up, asynchronous
key_code  output  4  accepted key code = {col[1:0], row[1:0]}
key_valid  output  1  key_code holds an unconsumed code
key_ready  input  1  consumer accepts the code when key_valid && key_ready
key_held  output  1  high while the accepted key remains pressed
overflow  output  1  sticky: a press was dropped because the holding register was full

Behaviour:
- Reset: when RST is high at a CLK edge, KEY_COL=4'b1110, column index=0, dwell counter=0, snapshot=0, FSM=IDLE, debounce counter=0, key_code=0, key_valid=0, key_held=0, overflow=0. Reset applied mid-scan, mid-debounce or with a code pending discards everything.
- KEY_ROW passes through a 2-flop synchronizer before use and is inverted to active-high.
- Scan: the dwell counter runs 0..SCAN_DIV-1. On its last count, the synchronized rows are written into snapshot bits [col*4 +: 4], the column index increments (wrapping 3->0), and KEY_COL = ~(1<<col).
- Frame: completes when column 3 is sampled. Period = 4*SCAN_DIV cycles.
- Frame classification, evaluated in the cycle after frame completion:
  - NONE: 0 bits set.
  - SINGLE(code): exactly 1 bit set.
  - MULTI: 2 or more bits set; treated as NONE (ghost rejection).
- FSM, advanced once per frame:
  - IDLE: on SINGLE(c), latch cand=c, cnt=1, go to DEBOUNCE (if DEBOUNCE_CNT=1, accept immediately).
  - DEBOUNCE: on SINGLE(cand), cnt++; when cnt reaches DEBOUNCE_CNT, accept cand and go to PRESSED. On SINGLE(other), set cand=other, cnt=1. On NONE or MULTI, return to IDLE.
  - PRESSED: key_held=1. A frame that is not SINGLE(cand) counts as a release frame; SINGLE(cand) resets the release count. After DEBOUNCE_CNT consecutive release frames, go to IDLE and set key_held=0. A different key cannot be accepted until the release completes.
- Accept: at the FSM-update edge:
  - If key_valid=0, or key_valid&&key_ready in that same cycle: key_code<=cand, key_valid<=1 (a new load wins over a simultaneous consume).
  - Otherwise: the code is dropped, overflow<=1, and key_code is left unchanged.
- Latency: key_valid rises 1 cycle after completion of the DEBOUNCE_CNT-th matching frame.
- Handshake: key_code is stable while key_valid=1. key_valid clears on the edge where key_valid&&key_ready and no accept occurs. key_ready with key_valid=0 has no effect.
- overflow is cleared only by RST.

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: in PRESSED, every REPEAT_FRAMES consecutive SINGLE(cand) frames trigger an accept of cand, following the normal accept and overflow rules. The repeat counter resets on entering PRESSED and on any release frame.
- Undefined: exactly one accept per press; the REPEAT_FRAMES parameter is unused.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=2 (frame = 16 cycles).
1. Reset: assert RST for 2 cycles, KEY_ROW=4'b1111 -> KEY_COL=4'b1110, key_valid=0, key_held=0, overflow=0; KEY_COL steps 1101, 1011, 0111, 1110 every 4 cycles.
2. Single press: row 2 low while column 1 is driven, held 5 frames, key_ready=1 -> exactly one key_valid pulse with key_code=4'd6; key_held=1 until 2 release frames after release.
3. Bounce: key 6 present on alternate frames for 6 frames -> key_valid never asserts.
4. Ghost: keys 3 and 12 both held 5 frames -> no key_valid and key_held=0; release 12 -> key_code=3 accepted after 2 frames.
5. Backpressure: key_ready=0; press and release 5, then press 9 -> key_valid=1 with key_code=5, overflow=1; then key_ready=1 for 1 cycle -> key_valid=0.
6. Reset mid-debounce: RST asserted one frame after key 6 pressed -> no key_valid, KEY_COL=4'b1110; with KEYPAD_REPEAT_EN and REPEAT_FRAMES=3, hold 6 for 10 frames -> 3 accepts of code 6.
